eight_to_three_event_encoder: RTL and testbench
===============================================

// Module: eight_to_three_event_encoder
// PURPOSE
//   Return path of the 3-to-8 one-hot decode: collects event strobes on 8 lines,
//   holds each in a pending register and hands out one 3-bit line index at a time.
//   Output is a valid/ready stream. Arbitration is fixed-priority or round-robin.
//   Sits between per-line event sources and a single consumer.
// PARAMETERS
//   RR     0   0 = fixed priority (lowest index wins); 1 = round-robin after last served
// PORTS
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in         in   8  event strobes, sampled every rising edge; multi-hot allowed
//   clr        in   1  synchronous clear of all pending/output state
//   code_out   out  3  index of presented event
//   valid      out  1  code_out holds a pending event
//   ready      in   1  consumer accepts; handshake = valid && ready at the edge
//   pending    out  8  registered pending mask (includes presented bit)
//   overflow   out  1  sticky: an event merged into an already-pending bit
// BEHAVIOUR
//   Reset (rst_n=0, async): pending=0, valid=0, code_out=0, overflow=0, rr_ptr=7.
//   Pending update per edge: pend <= (pend & ~served) | in.
//     served = one-hot(code_out) on handshake, else 0.
//     in[i] set on the same edge as serve of i: bit stays 1 (new event), no overflow.
//   overflow <= overflow | |(in & pend & ~served).
//   Output states:
//     IDLE (valid=0): if pend!=0, select per policy from registered pend.
//       Load code_out and set valid=1 at the next edge.
//       Latency: in[i] high at edge E -> pending[i]=1 after E -> valid=1 after E+1.
//     PRESENT (valid=1): code_out, valid held stable until handshake.
//       Newly arriving higher-priority events do not preempt.
//       On handshake edge: select from (pend & ~served), same-edge in excluded.
//       Non-empty -> reload code_out, stay PRESENT (back-to-back, 1 event/cycle).
//       Empty -> valid=0, IDLE; code_out keeps last value.
//   Selection:
//     RR=0: lowest set index.
//     RR=1: first set index scanning rr_ptr+1, rr_ptr+2 ... mod 8 (wraps 7->0).
//       rr_ptr <= code_out on each handshake.
//   clr=1 at edge: pend=0, valid=0, overflow=0, rr_ptr=7, in ignored that edge.
//     clr overrides handshake/events; code_out unchanged.
//   Reset mid-operation: immediate return to reset values; in-flight event lost, no handshake.
//   ready while valid=0 has no effect. All outputs registered; no comb in->out path.
// TESTING
//   1 Reset, in=8'h20 one cycle, ready=1 -> valid after 2 edges, code_out=5,
//     one handshake, pending=0, valid drops.
//   2 RR=0, in=8'hA5 once, ready=1 -> codes 0,2,5,7 on consecutive cycles, then valid=0.
//   3 RR=1, in=8'hFF held high, ready=1 -> code_out 0,1,..7,0,1 wrapping;
//     overflow=1 after second sample.
//   4 ready=0 with valid=1 code=3, then in=8'h01 -> code_out stays 3, valid stays 1
//     until ready; next code=0.
//   5 Serve of bit 4 coincides with in=8'h10 -> pending[4] stays 1, overflow stays 0,
//     code 4 presented again.
//   6 clr while valid=1 and in=8'h0F -> next cycle valid=0, pending=0, overflow=0;
//     rst_n pulse mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/eight_to_three_event_encoder.sv
// eight_to_three_event_encoder
//   Collects event strobes on 8 lines into a pending mask and hands out one
//   3-bit line index at a time on a valid/ready stream. Arbitration is
//   fixed-priority (lowest index) or round-robin after the last served line.
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in        8 event strobes, sampled every edge, multi-hot allowed
//   clr       synchronous clear of pending/output state (code_out kept)
//   code_out  index of the presented event
//   valid     code_out holds a pending event
//   ready     consumer accept; handshake = valid && ready at the edge
//   pending   registered pending mask (includes the presented bit)
//   overflow  sticky: an event merged into an already-pending bit
module eight_to_three_event_encoder #(
    parameter bit RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       clr,
    output logic [2:0] code_out,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [0:0]   state_q, state_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] pend_q, pend_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic         hs;
    logic [N-1:0] served;
    logic [N-1:0] avail;
    logic [W-1:0] eff_ptr;
    logic [W-1:0] pick;

    // Lowest set index; result is don't-care when mask is empty.
    function automatic logic [W-1:0] pick_low(input logic [N-1:0] mask);
        logic [W-1:0] res;
        res = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res = W'(i);
            end
        end
        return res;
    endfunction

    // First set index scanning ptr+1, ptr+2, ... with wrap 7->0.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] mask,
                                             input logic [W-1:0] ptr);
        logic [W-1:0] res;
        logic [W-1:0] idx;
        logic         found;
        res   = ptr;
        found = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = ptr + W'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Handshake, served bit and the candidate set (same-edge arrivals excluded).
    always_comb begin
        hs      = (state_q == S_PRESENT) && ready;
        served  = hs ? (N'(1) << code_q) : '0;
        avail   = pend_q & ~served;
        // Pointer moves to the served line on this very edge, so the reload
        // already scans from just after it.
        eff_ptr = hs ? code_q : rr_ptr_q;
        pick    = RR ? pick_rr(avail, eff_ptr) : pick_low(avail);
    end

    // Next-state logic for the pending mask and the output stream.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        pend_d   = avail | in;
        ovf_d    = ovf_q | (|(in & avail));
        rr_ptr_d = eff_ptr;

        case (state_q)
            S_IDLE: begin
                if (|avail) begin
                    code_d  = pick;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (hs) begin
                    if (|avail) begin
                        code_d = pick;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear wins over events and handshake; code_out keeps its value.
        if (clr) begin
            state_d  = S_IDLE;
            code_d   = code_q;
            pend_d   = '0;
            ovf_d    = 1'b0;
            rr_ptr_d = PTR_RST;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            rr_ptr_q <= PTR_RST;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign code_out = code_q;
    assign valid    = (state_q == S_PRESENT);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_eight_to_three_event_encoder.sv
// Bench for eight_to_three_event_encoder: one fixed-priority and one
// round-robin instance driven by the same stimulus. Expected codes are
// queued per instance and checked at every handshake.
module tb_eight_to_three_event_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] ev;
    logic       clr;
    logic       ready;

    logic [2:0] fp_code, rr_code;
    logic       fp_valid, rr_valid;
    logic [7:0] fp_pend, rr_pend;
    logic       fp_ovf, rr_ovf;

    logic [2:0] q_fp[$];
    logic [2:0] q_rr[$];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  pat;
        int          hold;
        int          n;
        logic [63:0] fp;   // one code per hex digit, first code leftmost
        logic [63:0] rr;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    eight_to_three_event_encoder #(.RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in(ev), .clr(clr),
        .code_out(fp_code), .valid(fp_valid), .ready(ready),
        .pending(fp_pend), .overflow(fp_ovf)
    );

    eight_to_three_event_encoder #(.RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in(ev), .clr(clr),
        .code_out(rr_code), .valid(rr_valid), .ready(ready),
        .pending(rr_pend), .overflow(rr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops and compares on each handshake about to happen at the next edge.
    task automatic monitor();
        logic [2:0] e;
        if (rst_n && !clr && ready) begin
            if (fp_valid) begin
                if (q_fp.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL fp_unexpected_hs: got code %0d expected none", fp_code);
                end else begin
                    e = q_fp.pop_front();
                    chk("fp_hs_code", 8'(fp_code), 8'(e));
                end
            end
            if (rr_valid) begin
                if (q_rr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rr_unexpected_hs: got code %0d expected none", rr_code);
                end else begin
                    e = q_rr.pop_front();
                    chk("rr_hs_code", 8'(rr_code), 8'(e));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_codes(input logic [63:0] codes, input int n, input bit to_rr);
        logic [63:0] sh;
        for (int i = 0; i < n; i++) begin
            sh = codes >> (4 * (n - 1 - i));
            if (to_rr) q_rr.push_back(sh[2:0]);
            else       q_fp.push_back(sh[2:0]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ev    = 8'h00;
        clr   = 1'b0;
        ready = 1'b0;
        q_fp.delete();
        q_rr.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic bit idle_all();
        return (q_fp.size() == 0) && (q_rr.size() == 0) && !fp_valid && !rr_valid
               && (fp_pend == 8'h00) && (rr_pend == 8'h00);
    endfunction

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !idle_all()) begin
            tick();
            c++;
        end
        n_cmp++;
        if (!idle_all()) begin
            n_err++;
            $display("FAIL %s_drain: got %0d/%0d codes left expected 0/0 within %0d cycles",
                     name, q_fp.size(), q_rr.size(), budget);
        end
    endtask

    initial begin
        vecs[0] = '{pat: 8'h20, hold: 1,  n: 1,  fp: 64'h5,                rr: 64'h5,                ovf: 1'b0};
        vecs[1] = '{pat: 8'hA5, hold: 1,  n: 4,  fp: 64'h0257,             rr: 64'h0257,             ovf: 1'b0};
        vecs[2] = '{pat: 8'hFF, hold: 10, n: 16, fp: 64'h0101010101234567, rr: 64'h0123456701234567, ovf: 1'b1};
        vecs[3] = '{pat: 8'h81, hold: 1,  n: 2,  fp: 64'h07,               rr: 64'h07,               ovf: 1'b0};
        vecs[4] = '{pat: 8'h3C, hold: 2,  n: 4,  fp: 64'h2345,             rr: 64'h2345,             ovf: 1'b1};

        rst_n = 1'b0;
        ev    = 8'h00;
        clr   = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        chk("fp_rst_valid", 8'(fp_valid), 8'h00);
        chk("fp_rst_code",  8'(fp_code),  8'h00);
        chk("fp_rst_pend",  fp_pend,      8'h00);
        chk("fp_rst_ovf",   8'(fp_ovf),   8'h00);
        chk("rr_rst_valid", 8'(rr_valid), 8'h00);
        chk("rr_rst_pend",  rr_pend,      8'h00);
        rst_n = 1'b1;

        // Table-driven bursts with ready held high.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            ready = 1'b1;
            push_codes(vecs[v].fp, vecs[v].n, 1'b0);
            push_codes(vecs[v].rr, vecs[v].n, 1'b1);
            for (int h = 0; h < vecs[v].hold; h++) begin
                ev = vecs[v].pat;
                tick();
                if (h == 0) begin
                    chk("fp_first_pend",  fp_pend,      vecs[v].pat);
                    chk("fp_first_valid", 8'(fp_valid), 8'h00);
                    chk("rr_first_pend",  rr_pend,      vecs[v].pat);
                end
            end
            ev = 8'h00;
            drain("vec", 64);
            chk("fp_vec_ovf", 8'(fp_ovf), 8'(vecs[v].ovf));
            chk("rr_vec_ovf", 8'(rr_ovf), 8'(vecs[v].ovf));
        end

        // Stall: presented code holds while ready is low, no preemption.
        do_reset();
        ev = 8'h08;
        tick();
        ev = 8'h00;
        tick();
        chk("stall_fp_valid", 8'(fp_valid), 8'h01);
        chk("stall_fp_code",  8'(fp_code),  8'h03);
        ev = 8'h01;
        tick();
        ev = 8'h00;
        tick();
        chk("stall_fp_code2", 8'(fp_code),  8'h03);
        chk("stall_fp_valid2", 8'(fp_valid), 8'h01);
        chk("stall_rr_code2", 8'(rr_code),  8'h03);
        chk("stall_fp_pend",  fp_pend,      8'h09);
        push_codes(64'h30, 2, 1'b0);
        push_codes(64'h30, 2, 1'b1);
        ready = 1'b1;
        drain("stall", 16);

        // Serve of bit 4 coincides with a new event on line 4.
        do_reset();
        ready = 1'b1;
        ev = 8'h10;
        tick();
        ev = 8'h00;
        tick();
        chk("coin_fp_code", 8'(fp_code), 8'h04);
        push_codes(64'h44, 2, 1'b0);
        push_codes(64'h44, 2, 1'b1);
        ev = 8'h10;
        tick();
        ev = 8'h00;
        chk("coin_fp_pend",  fp_pend,      8'h10);
        chk("coin_fp_ovf",   8'(fp_ovf),   8'h00);
        chk("coin_rr_ovf",   8'(rr_ovf),   8'h00);
        chk("coin_fp_valid", 8'(fp_valid), 8'h00);
        tick();
        chk("coin_fp_valid2", 8'(fp_valid), 8'h01);
        chk("coin_fp_code2",  8'(fp_code),  8'h04);
        drain("coin", 16);

        // Clear while presenting, with overflow set and events arriving.
        do_reset();
        ev = 8'h0E;
        tick();
        tick();
        ev = 8'h00;
        chk("clr_pre_ovf",   8'(fp_ovf),   8'h01);
        chk("clr_pre_code",  8'(fp_code),  8'h01);
        chk("clr_pre_valid", 8'(rr_valid), 8'h01);
        clr   = 1'b1;
        ev    = 8'h0F;
        ready = 1'b1;
        tick();
        clr   = 1'b0;
        ev    = 8'h00;
        chk("clr_fp_valid", 8'(fp_valid), 8'h00);
        chk("clr_fp_pend",  fp_pend,      8'h00);
        chk("clr_fp_ovf",   8'(fp_ovf),   8'h00);
        chk("clr_rr_pend",  rr_pend,      8'h00);
        chk("clr_fp_code",  8'(fp_code),  8'h01);
        tick();
        chk("clr_after_valid", 8'(fp_valid), 8'h00);

        // Asynchronous reset in the middle of a burst.
        ev = 8'h0F;
        tick();
        ev = 8'h00;
        push_codes(64'h0, 1, 1'b0);
        push_codes(64'h0, 1, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("arst_fp_valid", 8'(fp_valid), 8'h00);
        chk("arst_fp_code",  8'(fp_code),  8'h00);
        chk("arst_fp_pend",  fp_pend,      8'h00);
        chk("arst_rr_valid", 8'(rr_valid), 8'h00);
        chk("arst_rr_pend",  rr_pend,      8'h00);
        tick();
        rst_n = 1'b1;
        chk("arst_fp_q_left", 8'(q_fp.size()), 8'h00);
        chk("arst_rr_q_left", 8'(q_rr.size()), 8'h00);
        tick();
        chk("arst_after_valid", 8'(fp_valid), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
